// File: rtl/lsu_ctrl.sv
// Load/store unit: sizes core loads/stores and issues word-aligned bus transactions.
// Accesses that cross a word boundary are split into a LO and a HI transaction.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  is_load,
    input  logic [1:0]  is_store,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic        resp_valid,
    output logic [31:0] rd_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, REQ_LO, RSP_LO, REQ_HI, RSP_HI, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] op_addr, op_wdata, lo_word, hi_word;
    logic        op_store, op_load, op_signed;
    logic [2:0]  op_size;

    logic        dec_store, dec_load, dec_signed;
    logic [2:0]  dec_size;

    logic [1:0]  offset;
    logic [4:0]  bit_shift;
    logic [3:0]  base_mask;
    logic [7:0]  mask;
    logic        split;
    logic [63:0] wshift;
    logic [31:0] lo_addr, hi_addr, shifted, load_val;

    // A nonzero store encoding wins over any load encoding.
    always_comb begin
        dec_store  = (is_store != 2'b00);
        dec_load   = 1'b0;
        dec_signed = 1'b0;
        dec_size   = 3'd4;
        if (dec_store) begin
            case (is_store)
                2'b01:   dec_size = 3'd1;
                2'b10:   dec_size = 3'd2;
                default: dec_size = 3'd4;
            endcase
        end else begin
            case (is_load)
                3'b001: begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = 3'd1; end
                3'b010: begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = 3'd2; end
                3'b011: begin dec_load = 1'b1; dec_size = 3'd4; end
                3'b101: begin dec_load = 1'b1; dec_size = 3'd1; end
                3'b110: begin dec_load = 1'b1; dec_size = 3'd2; end
                default: ;
            endcase
        end
    end

    always_comb begin
        offset    = op_addr[1:0];
        bit_shift = {offset, 3'b000};
        case (op_size)
            3'd1:    base_mask = 4'b0001;
            3'd2:    base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
        mask    = {4'b0000, base_mask} << offset;
        split   = |mask[7:4];
        // Upper half of the shifted store data is exactly the HI-lane data.
        wshift  = {32'h0, op_wdata} << bit_shift;
        lo_addr = {op_addr[31:2], 2'b00};
        hi_addr = lo_addr + 32'd4;
        shifted = 32'({hi_word, lo_word} >> bit_shift);
        case (op_size)
            3'd1:    load_val = op_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                          : {24'h0, shifted[7:0]};
            3'd2:    load_val = op_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                          : {16'h0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        rd_data    = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = (dec_store || dec_load) ? REQ_LO : DONE;
            end
            REQ_LO: begin
                mem_req   = 1'b1;
                mem_we    = op_store;
                mem_addr  = lo_addr;
                mem_be    = op_store ? mask[3:0] : 4'b0000;
                mem_wdata = op_store ? wshift[31:0] : 32'h0;
                if (mem_gnt)
                    state_nxt = !op_store ? RSP_LO : (split ? REQ_HI : DONE);
            end
            RSP_LO: if (mem_rvalid) state_nxt = split ? REQ_HI : DONE;
            REQ_HI: begin
                mem_req   = 1'b1;
                mem_we    = op_store;
                mem_addr  = hi_addr;
                mem_be    = op_store ? mask[7:4] : 4'b0000;
                mem_wdata = op_store ? wshift[63:32] : 32'h0;
                if (mem_gnt)
                    state_nxt = op_store ? DONE : RSP_HI;
            end
            RSP_HI: if (mem_rvalid) state_nxt = DONE;
            DONE: begin
                resp_valid = 1'b1;
                rd_data    = op_load ? load_val : 32'h0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_addr   <= '0;
            op_wdata  <= '0;
            op_store  <= 1'b0;
            op_load   <= 1'b0;
            op_signed <= 1'b0;
            op_size   <= 3'd4;
            lo_word   <= '0;
            hi_word   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                op_addr   <= addr;
                op_wdata  <= wr_data;
                op_store  <= dec_store;
                op_load   <= dec_load;
                op_signed <= dec_signed;
                op_size   <= dec_size;
                lo_word   <= '0;
                hi_word   <= '0;
            end
            if (state == RSP_LO && mem_rvalid) lo_word <= mem_rdata;
            if (state == RSP_HI && mem_rvalid) hi_word <= mem_rdata;
        end
    end

endmodule
